// File: rtl/reg_write_arbiter_if.sv
// Bundle between the requesters and the shared-register write arbiter.
// Latency: none (plain signal bundle).
// Backpressure: requesters hold req/wdata until they see their gnt bit.
//
// Signals:
//   req/lock/wdata : requester -> arbiter (per-requester request, burst lock, data)
//   gnt            : arbiter -> requester, one-hot-or-zero grant
//   reg_en/reg_d   : arbiter -> shared register write port
//   owner_id/busy  : arbiter status (last writer, burst in progress)
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_d;
  logic [IDW-1:0]           owner_id;
  logic                     busy;

  // Requester side: drives requests, observes grants and register port.
  modport master (
    output req, lock, wdata,
    input  gnt, reg_en, reg_d, owner_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, lock, wdata,
    output gnt, reg_en, reg_d, owner_id, busy
  );

endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one enabled D/Q register among NUM_REQ requesters, with bounded lock bursts.
// Latency: gnt is combinational; a transfer in cycle t drives reg_en/reg_d in cycle t+1.
// Backpressure: requests are not latched; a requester holds req/wdata until its gnt bit is seen.
//
// Ports:
//   clk      : posedge clock
//   rst      : synchronous active-high reset; forces gnt to zero and aborts any burst
//   bus      : slave modport of reg_write_arbiter_if (req/lock/wdata in; gnt, reg_en, reg_d,
//              owner_id, busy out)
module reg_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // With a burst cap of one, a lock can never extend ownership past the first transfer.
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic            reg_en_q;
  logic [WIDTH-1:0] reg_d_q;
  logic [IDW-1:0]  owner_id_q;
  logic            busy_q;

  logic [NUM_REQ-1:0] gnt_c;
  logic               xfer_c;
  logic [IDW-1:0]     win_c;

  logic               rr_found;
  logic [IDW-1:0]     rr_win;
  logic [IDW-1:0]     rr_cand;

  // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin scan: first requester at or after ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!rr_found && bus.req[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  // Next-state, grant and transfer decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = '0;
    xfer_c      = 1'b0;
    win_c       = '0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (rr_found) begin
            gnt_c[rr_win] = 1'b1;
            xfer_c        = 1'b1;
            win_c         = rr_win;
            if (bus.lock[rr_win] && CAN_LOCK) begin
              // Pointer stays put during the burst; rotation happens on release.
              state_d     = LOCKED;
              owner_d     = rr_win;
              burst_cnt_d = CW'(1);
            end else begin
              ptr_d = next_idx(rr_win);
            end
          end
        end

        LOCKED: begin
          win_c = owner_q;
          if (bus.req[owner_q]) begin
            gnt_c[owner_q] = 1'b1;
            xfer_c         = 1'b1;
            burst_cnt_d    = burst_cnt_q + CW'(1);
            // Release on dropped lock or when this transfer reaches the cap,
            // even if lock is still asserted.
            if (!bus.lock[owner_q] || (int'(burst_cnt_q) + 1 == MAX_BURST)) begin
              state_d = IDLE;
              ptr_d   = next_idx(owner_q);
            end
          end else begin
            // Owner walked away: give up the lock without a transfer.
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      reg_en_q    <= 1'b0;
      reg_d_q     <= '0;
      owner_id_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      reg_en_q    <= xfer_c;
      busy_q      <= (state_d == LOCKED);
      // Data and id hold their last value when nothing transfers.
      if (xfer_c) begin
        reg_d_q    <= bus.wdata[int'(win_c)*WIDTH +: WIDTH];
        owner_id_q <= win_c;
      end
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.reg_en   = reg_en_q;
  assign bus.reg_d    = reg_d_q;
  assign bus.owner_id = owner_id_q;
  assign bus.busy     = busy_q;

  gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_c));
  gnt_quiet_in_reset: assert property (@(posedge clk) rst |-> (gnt_c == '0));

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one enabled register (D/Q register with enable and synchronous clear) among NUM_REQ requesters. Each cycle it selects at most one requester, and that requester's data is presented to the register's `en`/`d` inputs one cycle later. Requesters may lock the register for a bounded burst of back-to-back writes. The block sits between requester logic and a shared configuration/data register in the sequential-circuit library.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: data width of the shared register.
- `MAX_BURST`, 4: maximum consecutive locked transfers per owner, ≥1.
- `IDW`, `$clog2(NUM_REQ)`: derived; owner id width.

Ports:
- `clk` input 1: clock, posedge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input NUM_REQ: per-requester write request.
- `lock` input NUM_REQ: per-requester burst request; qualified by `req`.
- `wdata` input NUM_REQ*WIDTH: requester i data at bits [i*WIDTH +: WIDTH].
- `gnt` output NUM_REQ: one-hot-or-zero grant, combinational. A transfer occurs when `req[i] && gnt[i]`.
- `reg_en` output 1: registered write enable to the shared register.
- `reg_d` output WIDTH: registered write data to the shared register.
- `owner_id` output IDW: registered index of the last transferring requester.
- `busy` output 1: registered; 1 while in LOCKED.

## Operation
- State: `state` ∈ {IDLE, LOCKED}, `ptr` (IDW bits, round-robin start), `owner` (IDW), `burst_cnt` (`$clog2(MAX_BURST+1)` bits).
- **IDLE:**
  - The winner is the first i with `req[i]`=1, scanning ptr, ptr+1, … with wrap mod NUM_REQ. `gnt[winner]`=1; all other grants are 0. No `req` means no grant.
  - On a transfer with `lock[winner]`=1 and MAX_BURST>1: go to LOCKED, set `owner`=winner and `burst_cnt`=1. `ptr` is unchanged.
  - On a transfer without lock, or with MAX_BURST=1: stay in IDLE and set `ptr`=(winner+1) mod NUM_REQ.
- **LOCKED:**
  - `gnt[owner]` = `req[owner]`. All other grants are 0, regardless of their `req`.
  - On a transfer: `burst_cnt`++. If `lock[owner]`=0, or `burst_cnt`+1 == MAX_BURST, go to IDLE with `ptr`=(owner+1) mod NUM_REQ. Otherwise stay in LOCKED.
  - If `req[owner]`=0 in a cycle: no transfer; go to IDLE with `ptr`=(owner+1) mod NUM_REQ.
- **Datapath:**
  - On any transfer: `reg_en`<=1, `reg_d`<=wdata[winner], `owner_id`<=winner.
  - Otherwise `reg_en`<=0; `reg_d` and `owner_id` hold their values.
- `busy` <= (next state == LOCKED).
- Register bits of `wdata` are passed through unmodified; no arithmetic on data.
- `lock` without `req` is ignored.

## Timing
- `gnt` depends combinationally on `req`, `lock`-independent state, `ptr`, and `owner`. No combinational path exists from `wdata` to any output.
- Latency: a transfer in cycle t gives `reg_en`=1 and `reg_d`=data in cycle t+1. The shared register's Q updates at the end of cycle t+1.
- Throughput: one transfer per cycle, sustained.
- Reset (sync, `rst`=1 at a posedge), after the edge:
  - State: IDLE, `ptr`=0, `owner`=0, `burst_cnt`=0.
  - Outputs: `reg_en`=0, `reg_d`=0, `owner_id`=0, `busy`=0.
- `gnt` is forced to 0 while `rst`=1.
- Reset mid-burst aborts the lock. No transfer occurs in the reset cycle.
- Simultaneous: all `req` high in IDLE with `ptr`=2 and NUM_REQ=4 → grant order 2,3,0,1,2…
- Lock expiry on the MAX_BURSTth transfer forces rotation even if `lock` stays high. The same requester may win again only after the round-robin pointer comes back to it.
- Requests are not latched. A requester must hold `req` and `wdata` until it sees `gnt`.

## Test plan
- **Reset:** hold `rst` 2 cycles with random `req`. Require `gnt`=0, `reg_en`=0, `reg_d`=0, `owner_id`=0, `busy`=0.
- **Round-robin fairness:** `req`=4'b1111, no lock, `wdata` = 0x10,0x11,0x12,0x13. Require `gnt` sequence 0001,0010,0100,1000,0001. `reg_d` follows one cycle later: 0x10,0x11,0x12,0x13.
- **Burst cap:** `req`=4'b0011, `lock[0]`=1 held, MAX_BURST=4. Require 4 grants to req0 with `busy`=1 during the burst, then a grant to req1. `owner_id` sequence: 0,0,0,0,1.
- **Early release:** req0 locks, then drops `lock[0]` on its 2nd transfer. Require IDLE next cycle, `busy`=0, and the next grant going to req1 (`req[1]`=1).
- **Owner abandons:** req0 locked, then `req[0]`=0 for one cycle while `req[2]`=1. Require no grant that cycle and `gnt`=0100 in the next cycle.
- **Reset mid-burst:** assert `rst` during the 2nd locked transfer. Require `busy`=0, `ptr`=0, and `gnt`=0001 after release when `req`=4'b1111.
